change_dispenser_ctrl: RTL and testbench
========================================

// Module: change_dispenser_ctrl
// PURPOSE
//  Sequences the single physical coin ejector shared by all change outputs of
//  automatic_machine. Accumulates change pulses (give_nickel/dime/doubledime)
//  into an owed balance in nickel units, tracks hopper stock and issues one
//  coin at a time over a req/done handshake, largest coin first, with timeout.
// PARAMETERS
//  OWED_W      5    width of owed balance (nickel units), saturating
//  CNT_W       6    width of each hopper stock counter, saturating
//  NICKEL_INIT 8    nickel stock loaded at reset
//  DIME_INIT   8    dime stock loaded at reset
//  GAP_CYCLES  2    idle cycles enforced after each completed eject (>=1)
//  TIMEOUT     15   max cycles in EJECT awaiting eject_done before FAULT
// PORTS
//  clock           in   1      system clock, rising edge
//  reset           in   1      asynchronous, active-low reset
//  give_nickel     in   1      1-cycle pulse: owe 5c  (+1 unit)
//  give_dime       in   1      1-cycle pulse: owe 10c (+2 units)
//  give_doubledime in   1      1-cycle pulse: owe 20c (+4 units)
//  refill_nickel   in   1      1-cycle pulse: nickel stock +1
//  refill_dime     in   1      1-cycle pulse: dime stock +1
//  eject_done      in   1      ejector acknowledge, sampled only in EJECT
//  eject_req       out  1      request ejector to drop one coin
//  eject_sel       out  2      00 none, 01 nickel, 10 dime; valid with eject_req
//  busy            out  1      state != IDLE or owed != 0
//  short_change    out  1      owed != 0 and no usable coin in stock
//  overflow        out  1      sticky: owed saturated at all-ones
//  fault           out  1      sticky: eject timeout
//  owed            out  OWED_W current balance, nickel units
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, owed=0, nickels=NICKEL_INIT,
//   dimes=DIME_INIT, eject_req=0, eject_sel=00, overflow=0, fault=0, timers=0.
//  Credit: owed_next = owed + n + 2d + 4dd - taken; simultaneous pulses all
//   count; clamp to 2^OWED_W-1 and set overflow if the unclamped sum exceeds it.
//  Refill: stock +1 per pulse, saturating at 2^CNT_W-1; legal in any state.
//  FSM (all outputs registered):
//   IDLE : if owed>=2 && dimes>0 -> take dime (owed-=2, dimes-=1), sel=10;
//          elif owed>=1 && nickels>0 -> take nickel (owed-=1, nickels-=1), sel=01;
//          decision edge moves to EJECT; else stay IDLE.
//   EJECT: eject_req=1, eject_sel held stable. eject_done=1 -> GAP, req=0,
//          sel=00. TIMEOUT cycles without done -> FAULT.
//   GAP  : req=0 for GAP_CYCLES cycles, then IDLE.
//   FAULT: req=0, sel=00, fault=1; credits/refills still accepted; exit only
//          via reset. Coin taken for the failed eject is not returned to owed.
//  Coin is deducted at the decision edge, so owed never goes negative.
//  Latency: pulse sampled edge N -> owed updated after N; decision edge N+1;
//   eject_req high in cycle after N+1. done sampled at edge M -> req low after M.
//  Credit arriving in same cycle as a deduction: both applied (net).
//  short_change = owed!=0 && !(owed>=2 && dimes>0) && nickels==0, combinational
//   from registers; owed==1 with only dimes in stock asserts it (no overpay).
//  eject_done outside EJECT ignored. Reset mid-EJECT drops req asynchronously.
// TESTING
//  1 give_doubledime pulse, stock 8/8, done 3 cycles after each req
//    -> two dime ejects (sel=10), owed 4->2->0, dimes 8->6, busy low after GAP.
//  2 give_nickel+give_dime same cycle -> owed=3; dime then nickel eject.
//  3 dimes=0 via 8 dime ejects, then give_dime -> two nickel ejects (sel=01).
//  4 nickels=0,dimes=0, give_nickel -> short_change=1, no req; refill_nickel
//    -> one nickel eject, short_change=0.
//  5 hold eject_done=0 for 15 cycles in EJECT -> fault=1, req=0, stays FAULT
//    until reset; reset restores owed=0, stock 8/8, fault=0.
//  6 owed=30 then give_doubledime -> owed=31, overflow=1 (sticky).

Source files
------------

// File: rtl/change_dispenser_ctrl_if.sv
// Coin ejector handshake: the controller requests one coin of a given type,
// and the ejector acknowledges with eject_done once the coin has dropped.
interface change_dispenser_ctrl_if;
  logic       eject_req;
  logic [1:0] eject_sel;
  logic       eject_done;

  modport master (
    output eject_req,
    output eject_sel,
    input  eject_done
  );

  modport slave (
    input  eject_req,
    input  eject_sel,
    output eject_done
  );
endinterface

// File: rtl/change_dispenser_ctrl.sv
// Shared change ejector sequencer: accumulates owed change in nickel units,
// tracks hopper stock and drops one coin at a time, largest coin first.
module change_dispenser_ctrl #(
  parameter int OWED_W      = 5,
  parameter int CNT_W       = 6,
  parameter int NICKEL_INIT = 8,
  parameter int DIME_INIT   = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  give_nickel,
  input  logic                  give_dime,
  input  logic                  give_doubledime,
  input  logic                  refill_nickel,
  input  logic                  refill_dime,
  change_dispenser_ctrl_if.master ej,
  output logic                  busy,
  output logic                  short_change,
  output logic                  overflow,
  output logic                  fault,
  output logic [OWED_W-1:0]     owed
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EJECT    = 2'd1,
    GAP      = 2'd2,
    FAULT_ST = 2'd3
  } state_t;

  localparam int SUM_W   = OWED_W + 3;
  localparam int STK_W   = CNT_W + 1;
  localparam int TMR_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [OWED_W-1:0] OWED_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [1:0]        SEL_NONE = 2'b00;
  localparam logic [1:0]        SEL_NICK = 2'b01;
  localparam logic [1:0]        SEL_DIME = 2'b10;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [CNT_W-1:0]   nickels;
  logic [CNT_W-1:0]   dimes;

  logic               take_dime;
  logic               take_nickel;
  logic [SUM_W-1:0]   owed_sum;
  logic               owed_ovf;

  function automatic logic [OWED_W-1:0] sat_owed(input logic [SUM_W-1:0] s);
    return (s > SUM_W'(OWED_MAX)) ? OWED_MAX : s[OWED_W-1:0];
  endfunction

  // Stock only decrements when nonzero, so the sum never underflows.
  function automatic logic [CNT_W-1:0] step_stock(input logic [CNT_W-1:0] cur,
                                                  input logic             add,
                                                  input logic             sub);
    logic [STK_W-1:0] s;
    s = {1'b0, cur} + STK_W'(add) - STK_W'(sub);
    return (s > {1'b0, CNT_MAX}) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  always_comb begin
    take_dime   = 1'b0;
    take_nickel = 1'b0;
    if (state == IDLE) begin
      if ((owed >= OWED_W'(2)) && (dimes != '0)) begin
        take_dime = 1'b1;
      end else if ((owed != '0) && (nickels != '0)) begin
        take_nickel = 1'b1;
      end
    end
  end

  // Credits and the coin just committed are netted in one sum before clamping.
  always_comb begin
    owed_sum = SUM_W'(owed)
             + SUM_W'(give_nickel)
             + (SUM_W'(give_dime) << 1)
             + (SUM_W'(give_doubledime) << 2)
             - (SUM_W'(take_dime) << 1)
             - SUM_W'(take_nickel);
    owed_ovf = (owed_sum > SUM_W'(OWED_MAX));
  end

  assign busy         = (state != IDLE) || (owed != '0);
  assign short_change = (owed != '0)
                      && !((owed >= OWED_W'(2)) && (dimes != '0))
                      && (nickels == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      timer        <= '0;
      owed         <= '0;
      nickels      <= CNT_W'(NICKEL_INIT);
      dimes        <= CNT_W'(DIME_INIT);
      ej.eject_req <= 1'b0;
      ej.eject_sel <= SEL_NONE;
      overflow     <= 1'b0;
      fault        <= 1'b0;
    end else begin
      owed    <= sat_owed(owed_sum);
      nickels <= step_stock(nickels, refill_nickel, take_nickel);
      dimes   <= step_stock(dimes, refill_dime, take_dime);
      if (owed_ovf) begin
        overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (take_dime) begin
            state        <= EJECT;
            timer        <= '0;
            ej.eject_req <= 1'b1;
            ej.eject_sel <= SEL_DIME;
          end else if (take_nickel) begin
            state        <= EJECT;
            timer        <= '0;
            ej.eject_req <= 1'b1;
            ej.eject_sel <= SEL_NICK;
          end
        end

        EJECT: begin
          if (ej.eject_done) begin
            state        <= GAP;
            timer        <= '0;
            ej.eject_req <= 1'b0;
            ej.eject_sel <= SEL_NONE;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            // The coin already deducted from owed is deliberately not refunded.
            state        <= FAULT_ST;
            timer        <= '0;
            ej.eject_req <= 1'b0;
            ej.eject_sel <= SEL_NONE;
            fault        <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        GAP: begin
          if (timer == TMR_W'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        FAULT_ST: begin
          ej.eject_req <= 1'b0;
          ej.eject_sel <= SEL_NONE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Bench for change_dispenser_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural coin-dispensing model.
module tb_change_dispenser_ctrl;

  localparam int OWED_MAX   = 31;
  localparam int CNT_MAX    = 63;
  localparam int N_INIT     = 8;
  localparam int D_INIT     = 8;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 15;

  localparam int PH_IDLE = 0;
  localparam int PH_EJ   = 1;
  localparam int PH_GAP  = 2;
  localparam int PH_FLT  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       give_nickel = 1'b0, give_dime = 1'b0, give_doubledime = 1'b0;
  logic       refill_nickel = 1'b0, refill_dime = 1'b0;
  logic       busy, short_change, overflow, fault;
  logic [4:0] owed;

  change_dispenser_ctrl_if ej ();

  change_dispenser_ctrl #(
    .OWED_W(5), .CNT_W(6), .NICKEL_INIT(N_INIT), .DIME_INIT(D_INIT),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .give_nickel(give_nickel),
    .give_dime(give_dime),
    .give_doubledime(give_doubledime),
    .refill_nickel(refill_nickel),
    .refill_dime(refill_dime),
    .ej(ej),
    .busy(busy),
    .short_change(short_change),
    .overflow(overflow),
    .fault(fault),
    .owed(owed)
  );

  always #5 clock = ~clock;

  // Behavioural model: balance, stock, and which phase of a coin drop we are in.
  int m_owed, m_nk, m_dm, m_phase, m_cnt, m_req, m_sel, m_ovf, m_flt, m_age;
  int vectors = 0, miscompares = 0, n_cmp = 0;
  int resp_delay = 3;
  bit rand_resp = 1'b0;
  bit rst_next = 1'b0;
  int ej_nk = 0, ej_dm = 0;
  logic prev_req = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_owed = 0; m_nk = N_INIT; m_dm = D_INIT;
    m_phase = PH_IDLE; m_cnt = 0; m_req = 0; m_sel = 0;
    m_ovf = 0; m_flt = 0; m_age = 0;
  endtask

  task automatic model_step(input int n, input int d, input int dd,
                            input int rn, input int rd, input int done);
    int credit, take, tn, td, sum, was_req;
    credit = n + 2 * d + 4 * dd;
    take = 0; tn = 0; td = 0;
    was_req = m_req;
    case (m_phase)
      PH_IDLE: begin
        if (m_owed >= 2 && m_dm > 0) begin
          take = 2; td = 1; m_phase = PH_EJ; m_req = 1; m_sel = 2; m_cnt = 0;
        end else if (m_owed >= 1 && m_nk > 0) begin
          take = 1; tn = 1; m_phase = PH_EJ; m_req = 1; m_sel = 1; m_cnt = 0;
        end
      end
      PH_EJ: begin
        if (done != 0) begin
          m_phase = PH_GAP; m_req = 0; m_sel = 0; m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt == TIMEOUT) begin
            m_phase = PH_FLT; m_req = 0; m_sel = 0; m_flt = 1;
          end
        end
      end
      PH_GAP: begin
        m_cnt++;
        if (m_cnt == GAP_CYCLES) m_phase = PH_IDLE;
      end
      default: ;
    endcase
    sum = m_owed + credit - take;
    if (sum > OWED_MAX) begin
      sum = OWED_MAX;
      m_ovf = 1;
    end
    m_owed = sum;
    m_nk = m_nk + rn - tn; if (m_nk > CNT_MAX) m_nk = CNT_MAX;
    m_dm = m_dm + rd - td; if (m_dm > CNT_MAX) m_dm = CNT_MAX;
    m_age = (m_req != 0 && was_req != 0) ? m_age + 1 : 0;
  endtask

  task automatic check_all();
    int m_busy, m_short;
    m_busy  = (m_phase != PH_IDLE || m_owed != 0) ? 1 : 0;
    m_short = (m_owed != 0 && !(m_owed >= 2 && m_dm > 0) && m_nk == 0) ? 1 : 0;
    chk("eject_req",    int'(ej.eject_req), m_req);
    chk("eject_sel",    int'(ej.eject_sel), m_sel);
    chk("owed",         int'(owed),         m_owed);
    chk("busy",         int'(busy),         m_busy);
    chk("short_change", int'(short_change), m_short);
    chk("overflow",     int'(overflow),     m_ovf);
    chk("fault",        int'(fault),        m_flt);
    if (ej.eject_req && !prev_req) begin
      if (ej.eject_sel == 2'b10) ej_dm++;
      else if (ej.eject_sel == 2'b01) ej_nk++;
    end
    prev_req = ej.eject_req;
  endtask

  task automatic cycle(input int n, input int d, input int dd, input int rn, input int rd);
    int done, was_req;
    @(negedge clock);
    check_all();
    reset = rst_next;
    give_nickel = 1'(n); give_dime = 1'(d); give_doubledime = 1'(dd);
    refill_nickel = 1'(rn); refill_dime = 1'(rd);
    done = (m_req != 0 && resp_delay > 0 && m_age >= resp_delay - 1) ? 1 : 0;
    if (m_req == 0 && rand_resp && $urandom_range(0, 7) == 0) done = 1;
    ej.eject_done = 1'(done);
    was_req = m_req;
    if (reset) model_step(n, d, dd, rn, rd, done);
    else model_reset();
    if (rand_resp && m_req != 0 && was_req == 0)
      resp_delay = ($urandom_range(0, 9) == 0) ? 16 : int'($urandom_range(1, 6));
    vectors++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_next = 1'b0;
    idle(2);
    rst_next = 1'b1;
    idle(1);
    ej_nk = 0; ej_dm = 0;
  endtask

  initial begin
    ej.eject_done = 1'b0;
    model_reset();

    // Reset state
    idle(2);
    chk("rst_owed", int'(owed), 0);
    chk("rst_req", int'(ej.eject_req), 0);
    chk("rst_busy", int'(busy), 0);
    rst_next = 1'b1;
    idle(1);
    ej_nk = 0; ej_dm = 0;

    // One double dime -> two dime ejects
    resp_delay = 3;
    cycle(0, 0, 1, 0, 0);
    idle(1);
    chk("t1_owed4", int'(owed), 4);
    idle(30);
    chk("t1_dimes", ej_dm, 2);
    chk("t1_nickels", ej_nk, 0);
    chk("t1_owed", int'(owed), 0);
    chk("t1_busy", int'(busy), 0);

    // Nickel and dime on the same cycle -> owed 3, dime then nickel
    ej_nk = 0; ej_dm = 0;
    cycle(1, 1, 0, 0, 0);
    idle(1);
    chk("t2_owed3", int'(owed), 3);
    idle(1);
    chk("t2_first_sel", int'(ej.eject_sel), 2);
    idle(25);
    chk("t2_dimes", ej_dm, 1);
    chk("t2_nickels", ej_nk, 1);

    // Exhaust dimes, then a dime owed comes out as two nickels
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0);
    idle(70);
    chk("t3_dimes", ej_dm, 8);
    chk("t3_owed0", int'(owed), 0);
    cycle(0, 1, 0, 0, 0);
    idle(20);
    chk("t3_nickels", ej_nk, 2);
    chk("t3_owed", int'(owed), 0);

    // Empty hoppers -> short_change until a nickel is refilled
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 0);
    idle(120);
    chk("t4_dimes", ej_dm, 8);
    chk("t4_nickels", ej_nk, 8);
    cycle(1, 0, 0, 0, 0);
    idle(5);
    chk("t4_short", int'(short_change), 1);
    chk("t4_noreq", int'(ej.eject_req), 0);
    cycle(0, 0, 0, 1, 0);
    idle(15);
    chk("t4_refill_eject", ej_nk, 9);
    chk("t4_short_clr", int'(short_change), 0);

    // Ejector never answers -> sticky fault, cleared only by reset
    do_reset();
    resp_delay = 0;
    cycle(1, 0, 0, 0, 0);
    idle(25);
    chk("t5_fault", int'(fault), 1);
    chk("t5_req", int'(ej.eject_req), 0);
    chk("t5_owed", int'(owed), 0);
    cycle(0, 1, 0, 0, 0);
    idle(5);
    chk("t5_credit_in_fault", int'(owed), 2);
    chk("t5_stuck", int'(fault), 1);
    do_reset();
    chk("t5_rst_fault", int'(fault), 0);
    chk("t5_rst_owed", int'(owed), 0);

    // Asynchronous reset in the middle of an eject
    cycle(1, 0, 0, 0, 0);
    idle(4);
    chk("t5_req_hi", int'(ej.eject_req), 1);
    #2 reset = 1'b0;
    rst_next = 1'b0;
    model_reset();
    #1 chk("t5_async_req", int'(ej.eject_req), 0);
    idle(1);
    rst_next = 1'b1;
    idle(1);

    // Fault parks the machine so credits accumulate up to saturation
    cycle(1, 0, 0, 0, 0);
    idle(25);
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    idle(1);
    chk("t6_owed30", int'(owed), 30);
    chk("t6_no_ovf", int'(overflow), 0);
    cycle(0, 0, 1, 0, 0);
    idle(1);
    chk("t6_owed31", int'(owed), 31);
    chk("t6_ovf", int'(overflow), 1);
    idle(5);
    chk("t6_ovf_sticky", int'(overflow), 1);

    // Randomized traffic
    rand_resp = 1'b1;
    resp_delay = 3;
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 600; i++) begin
        cycle(($urandom_range(0, 7) == 0) ? 1 : 0,
              ($urandom_range(0, 7) == 0) ? 1 : 0,
              ($urandom_range(0, 11) == 0) ? 1 : 0,
              ($urandom_range(0, 9) == 0) ? 1 : 0,
              ($urandom_range(0, 9) == 0) ? 1 : 0);
      end
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
